// File: rtl/stopwatch_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_time_ctrl
//  Purpose  : BCD mm:ss time keeper with count/hold/adjust modes and blink
//             blanking. Optional macro STOPWATCH_SATURATE_EN: stop at
//             MIN_MAX:SEC_MAX with a sticky overflow flag instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_time_ctrl #(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       clear,
  input  logic [1:0] state,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_blink,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       rollover
);

  typedef enum logic [1:0] {
    ST_COUNT   = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_ADJ_SEC = 2'd2,
    ST_ADJ_MIN = 2'd3
  } mode_e;

  localparam logic [3:0] C_SEC_MAX_T = 4'(SEC_MAX / 10);
  localparam logic [3:0] C_SEC_MAX_O = 4'(SEC_MAX % 10);
  localparam logic [3:0] C_MIN_MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] C_MIN_MAX_O = 4'(MIN_MAX % 10);

  // Treat anything at or beyond the terminal value as terminal so a field can never escape its range.
  function automatic logic at_max(input logic [7:0] v, input logic [3:0] mt, input logic [3:0] mo);
    return (v[7:4] > mt) || ((v[7:4] == mt) && (v[3:0] >= mo));
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] mt, input logic [3:0] mo);
    logic [7:0] r;
    if (at_max(v, mt, mo))     r = 8'h00;
    else if (v[3:0] >= 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  mode_e      mode;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       blink_phase_q, blink_phase_d;
  logic       rollover_q, rollover_d;
  logic       blank_min_q, blank_min_d;
  logic       blank_sec_q, blank_sec_d;
  logic       sec_at_max, min_at_max;

  assign mode       = mode_e'(state);
  assign sec_at_max = at_max(sec_q, C_SEC_MAX_T, C_SEC_MAX_O);
  assign min_at_max = at_max(min_q, C_MIN_MAX_T, C_MIN_MAX_O);

  always_comb begin
    sec_d         = sec_q;
    min_d         = min_q;
    blink_phase_d = blink_phase_q;
`ifdef STOPWATCH_SATURATE_EN
    rollover_d    = rollover_q;
`else
    rollover_d    = 1'b0;
`endif
    if (clear) begin
      sec_d         = 8'h00;
      min_d         = 8'h00;
      blink_phase_d = 1'b0;
      rollover_d    = 1'b0;
    end else begin
      case (mode)
        ST_COUNT: begin
          if (tick_1hz) begin
            if (sec_at_max && min_at_max) begin
`ifdef STOPWATCH_SATURATE_EN
              rollover_d = 1'b1;
`else
              sec_d      = 8'h00;
              min_d      = 8'h00;
              rollover_d = 1'b1;
`endif
            end else if (sec_at_max) begin
              sec_d = 8'h00;
              min_d = bcd_inc(min_q, C_MIN_MAX_T, C_MIN_MAX_O);
            end else begin
              sec_d = bcd_inc(sec_q, C_SEC_MAX_T, C_SEC_MAX_O);
            end
          end
        end
        ST_ADJ_SEC: if (tick_2hz) sec_d = bcd_inc(sec_q, C_SEC_MAX_T, C_SEC_MAX_O);
        ST_ADJ_MIN: if (tick_2hz) min_d = bcd_inc(min_q, C_MIN_MAX_T, C_MIN_MAX_O);
        default: ;
      endcase
      // Phase survives moves between the two adjust modes so the blink stays continuous.
      if ((mode == ST_ADJ_SEC) || (mode == ST_ADJ_MIN)) begin
        if (tick_blink) blink_phase_d = ~blink_phase_q;
      end else begin
        blink_phase_d = 1'b0;
      end
    end
    blank_sec_d = (mode == ST_ADJ_SEC) && blink_phase_d;
    blank_min_d = (mode == ST_ADJ_MIN) && blink_phase_d;
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sec_q         <= 8'h00;
      min_q         <= 8'h00;
      blink_phase_q <= 1'b0;
      rollover_q    <= 1'b0;
      blank_min_q   <= 1'b0;
      blank_sec_q   <= 1'b0;
    end else begin
      sec_q         <= sec_d;
      min_q         <= min_d;
      blink_phase_q <= blink_phase_d;
      rollover_q    <= rollover_d;
      blank_min_q   <= blank_min_d;
      blank_sec_q   <= blank_sec_d;
    end
  end

  assign min_tens  = min_q[7:4];
  assign min_ones  = min_q[3:0];
  assign sec_tens  = sec_q[7:4];
  assign sec_ones  = sec_q[3:0];
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;
  assign rollover  = rollover_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_time_ctrl
//  Purpose  : Vector table plus reference-model scoreboard for stopwatch_time_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stopwatch_time_ctrl;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       clear;
  logic [1:0] state;
  logic       tick_1hz, tick_2hz, tick_blink;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       blank_min, blank_sec, rollover;

  stopwatch_time_ctrl #(.SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX)) dut (
    .clk(clk), .RESET_N(RESET_N), .clear(clear), .state(state),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_blink(tick_blink),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .blank_min(blank_min), .blank_sec(blank_sec), .rollover(rollover)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tm;
    logic        bm;
    logic        bs;
    logic        ro;
  } exp_t;

  typedef struct {
    string      name;
    logic       clr;
    logic [1:0] st;
    logic       t1, t2, tb;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  int   m_min, m_sec;
  logic m_ph, m_ro;
  logic [1:0] m_st;

  function automatic logic [15:0] to_bcd(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic exp_t mk(input int mm, input int ss, input logic bm, input logic bs, input logic ro);
    exp_t e;
    e.tm = to_bcd(mm, ss); e.bm = bm; e.bs = bs; e.ro = ro;
    return e;
  endfunction

  function automatic exp_t model_out();
    return mk(m_min, m_sec, (m_st == 2'd3) && m_ph, (m_st == 2'd2) && m_ph, m_ro);
  endfunction

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_ph = 1'b0; m_ro = 1'b0; m_st = 2'd0;
  endtask

  task automatic model_step(input logic clr, input logic [1:0] st, input logic t1, input logic t2, input logic tb);
    logic wrap;
    wrap = 1'b0;
    m_st = st;
    if (clr) begin
      m_min = 0; m_sec = 0; m_ph = 1'b0; m_ro = 1'b0;
    end else begin
      case (st)
        2'd0: if (t1) begin
          if (m_sec == SEC_MAX && m_min == MIN_MAX) begin
            wrap = 1'b1;
`ifndef STOPWATCH_SATURATE_EN
            m_sec = 0; m_min = 0;
`endif
          end else if (m_sec == SEC_MAX) begin
            m_sec = 0; m_min = m_min + 1;
          end else begin
            m_sec = m_sec + 1;
          end
        end
        2'd2: if (t2) m_sec = (m_sec + 1) % (SEC_MAX + 1);
        2'd3: if (t2) m_min = (m_min + 1) % (MIN_MAX + 1);
        default: ;
      endcase
`ifdef STOPWATCH_SATURATE_EN
      m_ro = m_ro | wrap;
`else
      m_ro = wrap;
`endif
      if (st >= 2'd2) begin
        if (tb) m_ph = ~m_ph;
      end else begin
        m_ph = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input exp_t e);
    logic [15:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones};
    n_assert++;
    if (got !== e.tm || blank_min !== e.bm || blank_sec !== e.bs || rollover !== e.ro) begin
      n_fail++;
      $display("FAIL %s: got time=%h bm=%b bs=%b ro=%b, want time=%h bm=%b bs=%b ro=%b",
               name, got, blank_min, blank_sec, rollover, e.tm, e.bm, e.bs, e.ro);
    end
  endtask

  // One clock of stimulus; expectation comes from the table when given, else from the model.
  task automatic step_core(input string name, input logic clr, input logic [1:0] st,
                           input logic t1, input logic t2, input logic tb,
                           input logic use_tbl, input exp_t te);
    exp_t e;
    clear = clr; state = st; tick_1hz = t1; tick_2hz = t2; tick_blink = tb;
    model_step(clr, st, t1, t2, tb);
    sb_q.push_back(use_tbl ? te : model_out());
    @(posedge clk);
    #1;
    clear = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0;
    if (sb_q.size() == 0) begin
      n_assert++; n_fail++;
      $display("FAIL %s: scoreboard empty, got nothing, want one entry", name);
    end else begin
      e = sb_q.pop_front();
      check(name, e);
    end
  endtask

  task automatic step(input string name, input logic clr, input logic [1:0] st,
                      input logic t1, input logic t2, input logic tb);
    step_core(name, clr, st, t1, t2, tb, 1'b0, mk(0, 0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic set_time(input int mm, input int ss);
    step("preset_clr", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (mm) step("preset_min", 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
    repeat (ss) step("preset_sec", 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
  endtask

  // Asserts RESET_N between edges, checks outputs before any edge, then releases at a falling edge.
  task automatic async_reset(input string name);
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check(name, mk(0, 0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check({name, "_hold"}, mk(0, 0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    RESET_N = 1'b1;
    state = 2'd0;
  endtask

  task automatic add(input string n, input logic clr, input logic [1:0] st, input logic t1,
                     input logic t2, input logic tb, input exp_t e);
    vec_t v;
    v.name = n; v.clr = clr; v.st = st; v.t1 = t1; v.t2 = t2; v.tb = tb; v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    RESET_N = 1'b0; clear = 1'b0; state = 2'd0;
    tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0;
    model_reset();

    //          name           clr  st    t1   t2   tb     expected mm:ss bm bs ro
    add("adj_sec_inc",   1'b0, 2'd2, 1'b0, 1'b1, 1'b0, mk(0, 1, 1'b0, 1'b0, 1'b0));
    add("adj_sec_t1ign", 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, mk(0, 1, 1'b0, 1'b0, 1'b0));
    add("blink_1",       1'b0, 2'd2, 1'b0, 1'b0, 1'b1, mk(0, 1, 1'b0, 1'b1, 1'b0));
    add("blink_2",       1'b0, 2'd2, 1'b0, 1'b0, 1'b1, mk(0, 1, 1'b0, 1'b0, 1'b0));
    add("blink_3",       1'b0, 2'd2, 1'b0, 1'b0, 1'b1, mk(0, 1, 1'b0, 1'b1, 1'b0));
    add("adj_swap_keep", 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, mk(0, 1, 1'b1, 1'b0, 1'b0));
    add("adj_min_inc",   1'b0, 2'd3, 1'b0, 1'b1, 1'b1, mk(1, 1, 1'b0, 1'b0, 1'b0));
    add("pause_hold",    1'b0, 2'd1, 1'b1, 1'b1, 1'b1, mk(1, 1, 1'b0, 1'b0, 1'b0));
    add("count_inc",     1'b0, 2'd0, 1'b1, 1'b0, 1'b0, mk(1, 2, 1'b0, 1'b0, 1'b0));
    add("count_t2ign",   1'b0, 2'd0, 1'b0, 1'b1, 1'b0, mk(1, 2, 1'b0, 1'b0, 1'b0));
    add("clear_prio",    1'b1, 2'd0, 1'b1, 1'b0, 1'b0, mk(0, 0, 1'b0, 1'b0, 1'b0));
    add("after_clear",   1'b0, 2'd0, 1'b1, 1'b0, 1'b0, mk(0, 1, 1'b0, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", mk(0, 0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    RESET_N = 1'b1;

    // Asynchronous reset in the middle of counting at 12:34.
    set_time(12, 30);
    repeat (4) step("count_to_1234", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    async_reset("async_rst_count");

    // Asynchronous reset while the seconds field is blanked.
    step("pre_blink", 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    async_reset("async_rst_blank");

    foreach (vecs[i])
      step_core(vecs[i].name, vecs[i].clr, vecs[i].st, vecs[i].t1, vecs[i].t2, vecs[i].tb, 1'b1, vecs[i].e);

    set_time(0, 59);
    step("min_carry", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step("min_carry_idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    set_time(59, 59);
    step("wrap_tick", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step("wrap_after", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("wrap_resume", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step("wrap_idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("wrap_clear", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);

    set_time(5, 59);
    step("adj_sec_wrap", 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
    repeat (3) step("adj_sec_t1", 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    repeat (4) step("adj_sec_blink", 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);

    set_time(7, 30);
    repeat (10) step("pause_t1", 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    repeat (10) step("pause_t2", 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    step("adj_min_0730", 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);

    set_time(59, 58);
    step("adj_min_wrap", 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);

    set_time(10, 10);
    step("clear_vs_t1", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);

    // Mixed random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      step("random",
           ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
           ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
           ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_time_ctrl.md
Name: stopwatch_time_ctrl

Overview:
- Sequences the stopwatch minutes/seconds time registers according to the 2-bit mode from the stopwatch mode FSM.
- Consumes pre-divided tick enables, applies count, hold and adjust rules, and drives BCD digits plus per-field blank flags for the 7-segment display scanner.
- Sits between the mode FSM and the display driver; owns all time state.

Parameters:
- SEC_MAX, 59, terminal value of the seconds field (count wraps SEC_MAX -> 0).
- MIN_MAX, 59, terminal value of the minutes field.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear, from the debounced RESET button; single-cycle or level.
- state  in  2  mode: 0 COUNTING, 1 PAUSED, 2 ADJ_SECONDS, 3 ADJ_MINUTES.
- tick_1hz  in  1  one-cycle enable at 1 Hz.
- tick_2hz  in  1  one-cycle enable at 2 Hz.
- tick_blink  in  1  one-cycle enable at blink rate (about 4 Hz).
- min_tens  out  4  BCD minutes tens digit.
- min_ones  out  4  BCD minutes ones digit.
- sec_tens  out  4  BCD seconds tens digit.
- sec_ones  out  4  BCD seconds ones digit.
- blank_min  out  1  blank minutes digits this cycle.
- blank_sec  out  1  blank seconds digits this cycle.
- rollover  out  1  one-cycle pulse when the time wraps MIN_MAX:SEC_MAX -> 00:00.

Behaviour:
- Storage is four registered BCD digits; each ones digit wraps 9 -> 0 and carries into its tens digit. All outputs are registered.
- RESET_N low, asynchronously: all digits 0; blink_phase 0; rollover 0; blank_min 0; blank_sec 0.
- clear high: on the next edge all digits go to 0, blink_phase to 0, rollover to 0. clear takes priority over every tick in every state.
- COUNTING:
  - on tick_1hz, seconds +1.
  - at SEC_MAX, seconds -> 0 and minutes +1.
  - at MIN_MAX:SEC_MAX, both fields -> 0 and rollover is high for exactly the following cycle.
  - tick_2hz is ignored.
- PAUSED: all digits hold; every tick is ignored.
- ADJ_SECONDS:
  - on tick_2hz, seconds +1; SEC_MAX wraps to 0 with no carry into minutes.
  - tick_1hz is ignored; minutes hold.
- ADJ_MINUTES:
  - on tick_2hz, minutes +1; MIN_MAX wraps to 0.
  - seconds hold; rollover is never asserted.
- Latency: the digit change is visible on the edge that samples the tick, i.e. one cycle after the tick is presented.
- Blink:
  - tick_blink toggles blink_phase only while state is 2 or 3.
  - blink_phase is forced to 0 in states 0 and 1.
  - blank_sec = (state==2) & blink_phase; blank_min = (state==3) & blink_phase. Both are registered.
- Mode change on the same cycle as a tick: the tick is applied under the state value sampled in that cycle.
- Mode change between adjust states: blink_phase is not reset, so the blink continues without a glitch.
- Inputs arriving after a cleared or reset state: no spurious rollover; time resumes from 00:00.
- Digits always hold legal BCD. Neither field exceeds its MAX parameter, including when the field is entered via adjust.

Optional Feature:
- Macro name: STOPWATCH_SATURATE_EN.
- Defined: in COUNTING, time stops at MIN_MAX:SEC_MAX and further tick_1hz has no effect. rollover becomes a sticky overflow flag: set on the tick that would have wrapped, cleared only by clear or RESET_N. Adjust modes still wrap per field.
- Undefined: wrap to 00:00 with a one-cycle rollover pulse, as specified in Behaviour.

Test Plan:
- RESET_N low mid-count at 12:34 -> digits read 0,0,0,0 immediately (asynchronous); blank_min and blank_sec 0 while RESET_N is low.
- state=0, time 00:59, one tick_1hz -> 01:00 next cycle; rollover stays 0.
- state=0, time 59:59, one tick_1hz -> 00:00 with rollover high for one cycle. With STOPWATCH_SATURATE_EN defined: holds 59:59 and rollover stays high until clear.
- state=2, time 05:59, one tick_2hz -> 05:00 (no minute carry); tick_1hz pulses -> no change. Four tick_blink -> blank_sec sequence 1,0,1,0; blank_min stays 0.
- state=1 at 07:30 with 10 tick_1hz and 10 tick_2hz -> stays 07:30. Switch to state=3, one tick_2hz -> 08:30.
- clear and tick_1hz together at 10:10 in state=0 -> 00:00 next cycle; no increment, rollover 0.
